traffic_phase_controller: RTL and testbench
===========================================

Name: traffic_phase_controller

Overview:
Consumer end of the sensor path: takes the registered vehicle_detected / ped_detected flags and sequences the main-road, side-road and pedestrian phases. Tick-timed Moore FSM with latched requests, min/max green enforcement and all-red clearance. Drives the lamp outputs and a pedestrian acknowledge back toward the sensor side.

Parameters:
MIN_GREEN, 10, minimum green duration in ticks (main and side), >=1
MAX_GREEN, 30, maximum side-green duration in ticks, >=MIN_GREEN
YELLOW_TIME, 3, yellow duration in ticks, >=1
ALL_RED_TIME, 1, all-red clearance duration in ticks, >=1
WALK_TIME, 8, pedestrian walk duration in ticks, >=1
CNT_W, 8, timer width; all durations must be <= 2**CNT_W-1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  one-cycle timebase strobe; all timing counts ticks, not clocks
vehicle_detected  input  1  side-road vehicle present, registered, from sensor block
ped_detected  input  1  pedestrian request, registered, from sensor block
main_light  output  3  {red,yellow,green}, one-hot
side_light  output  3  {red,yellow,green}, one-hot
walk  output  1  pedestrian walk lamp
ped_ack  output  1  one-cycle pulse: pedestrian request served
state_o  output  3  current state encoding, for debug

Behaviour:
- Reset is asynchronous, active-high; clock is clk. On reset: state=MAIN_GREEN, timer=0, veh_pend=0, ped_pend=0, main_light=001, side_light=100, walk=0, ped_ack=0, state_o=0.
- States/encoding: MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED_1=2, SIDE_GREEN=3, SIDE_YELLOW=4, ALL_RED_2=5, PED_WALK=6; 7 is illegal and returns to MAIN_GREEN on the next clock.
- Lamps are a pure decode of the state register (no input-to-output path). MAIN_GREEN: main=001, side=100. MAIN_YELLOW: main=010, side=100. SIDE_GREEN: main=100, side=001. SIDE_YELLOW: main=100, side=010. ALL_RED_x and PED_WALK: both 100. walk=1 only in PED_WALK.
- Request latches: veh_pend is set in any cycle vehicle_detected=1 and cleared on the clock that enters SIDE_GREEN. ped_pend is set in any cycle ped_detected=1 and cleared on the clock that enters PED_WALK; the clear wins over a same-cycle set. A request arriving during PED_WALK re-latches.
- Timer: reset to 0 on every state change. On a clock with tick=1 and no transition, timer increments, saturating at all-ones. With tick=0, timer, state and exit checks are all frozen.
- Transitions are evaluated only on clocks with tick=1:
  - MAIN_GREEN -> MAIN_YELLOW when timer>=MIN_GREEN-1 and (veh_pend or ped_pend). With no requests, MAIN_GREEN rests indefinitely.
  - MAIN_YELLOW -> ALL_RED_1 when timer==YELLOW_TIME-1.
  - ALL_RED_1 -> PED_WALK if ped_pend, else SIDE_GREEN, when timer==ALL_RED_TIME-1. Pedestrian has priority.
  - SIDE_GREEN -> SIDE_YELLOW when (timer>=MIN_GREEN-1 and vehicle_detected=0) or timer==MAX_GREEN-1.
  - SIDE_YELLOW -> ALL_RED_2 when timer==YELLOW_TIME-1.
  - PED_WALK -> ALL_RED_2 when timer==WALK_TIME-1.
  - ALL_RED_2 -> MAIN_GREEN when timer==ALL_RED_TIME-1. Main road always regains green after any side or walk phase.
- Resulting phase lengths: each state lasts exactly N ticks for its duration N. MAIN_GREEN is >=MIN_GREEN ticks. SIDE_GREEN is MIN_GREEN..MAX_GREEN ticks.
- ped_ack: registered; high for exactly one clock, the first clock in which the state register holds PED_WALK.
- Pending vehicle request during PED_WALK: served on the next cycle after MAIN_GREEN has met its minimum.
- Reset mid-phase: immediate return to the reset values, independent of clk. Pending requests are lost.

Test Plan:
Use MIN_GREEN=4, MAX_GREEN=8, YELLOW_TIME=2, ALL_RED_TIME=1, WALK_TIME=3, CNT_W=4, tick=1 every clock.
- Idle: reset, then sensors low for 50 clocks -> state_o=0, main_light=001, side_light=100, walk=0, ped_ack=0 throughout.
- Vehicle pulse: 1-clock vehicle_detected pulse 1 clock after reset release -> MAIN_GREEN 4 clocks, MAIN_YELLOW 2, ALL_RED_1 1, SIDE_GREEN 4, SIDE_YELLOW 2, ALL_RED_2 1, then MAIN_GREEN; lamps match the decode at each step.
- Vehicle held: vehicle_detected held high -> SIDE_GREEN lasts exactly 8 clocks (max-out), then SIDE_YELLOW. Main then serves 4 clocks before the next side phase.
- Pedestrian: 1-clock ped_detected pulse -> after ALL_RED_1, PED_WALK for 3 clocks with walk=1 and both lights 100; ped_ack high only on the first PED_WALK clock.
- Simultaneous requests: ped and vehicle pulsed in the same clock -> PED_WALK first, then ALL_RED_2, MAIN_GREEN 4 clocks, then the side phase. ped_detected pulsed during PED_WALK -> re-latched and served on a later cycle.
- Tick gating and reset: tick=0 for 10 clocks mid-SIDE_GREEN -> state and lamps frozen. Async reset mid-SIDE_GREEN -> outputs return to reset values before the next clk edge, and there is no side phase afterward without a new request.

Source files
------------

// File: rtl/traffic_phase_controller.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_phase_controller
//  Description : Tick-timed Moore controller that sequences the main-road,
//                side-road and pedestrian phases from latched sensor
//                requests. It enforces min/max green times and all-red
//                clearance, and pulses ped_ack when a walk phase starts.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_controller #(
  parameter int MIN_GREEN    = 10,
  parameter int MAX_GREEN    = 30,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 1,
  parameter int WALK_TIME    = 8,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       vehicle_detected,
  input  logic       ped_detected,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_MAIN_GREEN  = 3'd0,
    S_MAIN_YELLOW = 3'd1,
    S_ALL_RED_1   = 3'd2,
    S_SIDE_GREEN  = 3'd3,
    S_SIDE_YELLOW = 3'd4,
    S_ALL_RED_2   = 3'd5,
    S_PED_WALK    = 3'd6,
    S_ILLEGAL     = 3'd7
  } state_t;

  // Exit thresholds: the timer counts completed ticks minus one, so a phase
  // of N ticks exits on the tick where the timer reads N-1.
  localparam logic [CNT_W-1:0] c_MIN_GREEN_M1 = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] c_MAX_GREEN_M1 = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] c_YELLOW_M1    = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] c_ALL_RED_M1   = CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] c_WALK_M1      = CNT_W'(WALK_TIME - 1);
  localparam logic [CNT_W-1:0] c_TIMER_MAX    = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_timer;
  logic             r_veh_pend;
  logic             r_ped_pend;
  logic             r_ped_ack;
  logic             w_state_change;
  logic             w_enter_side;
  logic             w_enter_walk;

  assign w_state_change = (w_next != r_state);
  assign w_enter_side   = (w_next == S_SIDE_GREEN) && (r_state != S_SIDE_GREEN);
  assign w_enter_walk   = (w_next == S_PED_WALK) && (r_state != S_PED_WALK);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_MAIN_GREEN;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; exits are only evaluated on tick clocks, except that
  // the unused encoding recovers to MAIN_GREEN unconditionally.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_MAIN_GREEN: begin
        if (tick && (r_timer >= c_MIN_GREEN_M1) && (r_veh_pend || r_ped_pend)) begin
          w_next = S_MAIN_YELLOW;
        end
      end
      S_MAIN_YELLOW: begin
        if (tick && (r_timer == c_YELLOW_M1)) begin
          w_next = S_ALL_RED_1;
        end
      end
      S_ALL_RED_1: begin
        if (tick && (r_timer == c_ALL_RED_M1)) begin
          w_next = r_ped_pend ? S_PED_WALK : S_SIDE_GREEN;
        end
      end
      S_SIDE_GREEN: begin
        if (tick && (((r_timer >= c_MIN_GREEN_M1) && !vehicle_detected) ||
                     (r_timer == c_MAX_GREEN_M1))) begin
          w_next = S_SIDE_YELLOW;
        end
      end
      S_SIDE_YELLOW: begin
        if (tick && (r_timer == c_YELLOW_M1)) begin
          w_next = S_ALL_RED_2;
        end
      end
      S_PED_WALK: begin
        if (tick && (r_timer == c_WALK_M1)) begin
          w_next = S_ALL_RED_2;
        end
      end
      S_ALL_RED_2: begin
        if (tick && (r_timer == c_ALL_RED_M1)) begin
          w_next = S_MAIN_GREEN;
        end
      end
      default: begin
        w_next = S_MAIN_GREEN;
      end
    endcase
  end

  // Phase timer: cleared on every state change, counts ticks, saturates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_state_change) begin
      r_timer <= '0;
    end else if (tick && (r_timer != c_TIMER_MAX)) begin
      r_timer <= r_timer + CNT_W'(1);
    end
  end

  // Request latches; clearing on phase entry takes priority over a new set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_veh_pend <= 1'b0;
      r_ped_pend <= 1'b0;
    end else begin
      if (w_enter_side) begin
        r_veh_pend <= 1'b0;
      end else if (vehicle_detected) begin
        r_veh_pend <= 1'b1;
      end
      if (w_enter_walk) begin
        r_ped_pend <= 1'b0;
      end else if (ped_detected) begin
        r_ped_pend <= 1'b1;
      end
    end
  end

  // Acknowledge pulse aligned with the first clock spent in PED_WALK
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ped_ack <= 1'b0;
    end else begin
      r_ped_ack <= w_enter_walk;
    end
  end

  // Lamp decode straight from the state register ({red,yellow,green})
  always_comb begin
    main_light = 3'b100;
    side_light = 3'b100;
    walk       = 1'b0;
    case (r_state)
      S_MAIN_GREEN:  main_light = 3'b001;
      S_MAIN_YELLOW: main_light = 3'b010;
      S_SIDE_GREEN:  side_light = 3'b001;
      S_SIDE_YELLOW: side_light = 3'b010;
      S_PED_WALK:    walk       = 1'b1;
      default: begin
        main_light = 3'b100;
        side_light = 3'b100;
      end
    endcase
  end

  assign ped_ack = r_ped_ack;
  assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_phase_controller
//  Description : Self-checking bench for traffic_phase_controller. A
//                phase/elapsed-tick model predicts every output each cycle;
//                literal sequences pin the directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_controller;

  localparam int MING  = 4;
  localparam int MAXG  = 8;
  localparam int YEL   = 2;
  localparam int AR    = 1;
  localparam int WALKT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b1;
  logic       vehicle_detected = 1'b0;
  logic       ped_detected = 1'b0;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic       ped_ack;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  traffic_phase_controller #(
    .MIN_GREEN   (MING),
    .MAX_GREEN   (MAXG),
    .YELLOW_TIME (YEL),
    .ALL_RED_TIME(AR),
    .WALK_TIME   (WALKT),
    .CNT_W       (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .tick            (tick),
    .vehicle_detected(vehicle_detected),
    .ped_detected    (ped_detected),
    .main_light      (main_light),
    .side_light      (side_light),
    .walk            (walk),
    .ped_ack         (ped_ack),
    .state_o         (state_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Phases: 0 main green, 1 main yellow, 2 all red 1, 3 side green,
  // 4 side yellow, 5 all red 2, 6 walk. m_el = ticks already spent in phase.
  int m_phase;
  int m_el;
  bit m_veh;
  bit m_ped;
  bit m_ack;
  int m_next;

  function automatic int next_phase(int ph, int done, bit vp, bit pp, bit vd, bit tk);
    int n;
    n = ph;
    if (tk) begin
      case (ph)
        0: if (done >= MING && (vp || pp)) n = 1;
        1: if (done >= YEL) n = 2;
        2: if (done >= AR) n = pp ? 6 : 3;
        3: if ((done >= MING && !vd) || done >= MAXG) n = 4;
        4: if (done >= YEL) n = 5;
        5: if (done >= AR) n = 0;
        6: if (done >= WALKT) n = 5;
        default: n = 0;
      endcase
    end
    return n;
  endfunction

  // {main, side, walk} seen by a road user in each phase
  function automatic logic [6:0] lamps(int ph);
    case (ph)
      0: return {3'b001, 3'b100, 1'b0};
      1: return {3'b010, 3'b100, 1'b0};
      3: return {3'b100, 3'b001, 1'b0};
      4: return {3'b100, 3'b010, 1'b0};
      6: return {3'b100, 3'b100, 1'b1};
      default: return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  assign m_next = next_phase(m_phase, m_el + 1, m_veh, m_ped, vehicle_detected, tick);

  // Model advances on the same edges as the design
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0;
      m_el    <= 0;
      m_veh   <= 1'b0;
      m_ped   <= 1'b0;
      m_ack   <= 1'b0;
    end else begin
      m_phase <= m_next;
      m_el    <= (m_next != m_phase) ? 0 : (tick ? m_el + 1 : m_el);
      m_ack   <= (m_next == 6) && (m_phase != 6);
      m_veh   <= (m_veh | vehicle_detected) & !((m_next == 3) && (m_phase != 3));
      m_ped   <= (m_ped | ped_detected) & !((m_next == 6) && (m_phase != 6));
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_model();
    logic [10:0] act;
    logic [10:0] exp;
    act = {state_o, main_light, side_light, walk, ped_ack};
    exp = {3'(m_phase), lamps(m_phase), m_ack};
    check("model_outputs", 32'(act), 32'(exp));
  endtask

  task automatic step();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic do_reset();
    tick = 1'b1;
    vehicle_detected = 1'b0;
    ped_detected = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cmp_model();
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int n;
    n = 0;
    while (state_o !== s && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) check(name, 32'(state_o), 32'(s));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seq_v[15];
    int seq_p[12];
    int cnt;
    bit saw_side;

    seq_v = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 4, 4, 5, 0};
    seq_p = '{0, 0, 0, 0, 1, 1, 2, 6, 6, 6, 5, 0};

    #1;
    // Idle after reset
    do_reset();
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_lamps", 32'({main_light, side_light, walk, ped_ack}), 32'({3'b001, 3'b100, 2'b00}));
    for (int k = 0; k < 50; k++) begin
      step();
      check("idle_lamps", 32'({state_o, main_light, side_light, walk, ped_ack}),
            32'({3'd0, 3'b001, 3'b100, 2'b00}));
    end

    // Single vehicle pulse
    do_reset();
    check("veh_seq", 32'(state_o), 32'(seq_v[0]));
    for (int k = 1; k < 15; k++) begin
      step();
      check("veh_seq", 32'(state_o), 32'(seq_v[k]));
      if (k == 8) check("veh_side_lamp", 32'(side_light), 32'(3'b001));
      vehicle_detected = (k == 1);
    end

    // Single pedestrian pulse
    do_reset();
    for (int k = 1; k < 12; k++) begin
      step();
      check("ped_seq", 32'(state_o), 32'(seq_p[k]));
      if (k == 7) check("ped_ack_first", 32'({ped_ack, walk}), 32'(2'b11));
      if (k == 8) check("ped_ack_once", 32'({ped_ack, walk}), 32'(2'b01));
      ped_detected = (k == 1);
    end

    // Simultaneous requests plus a re-latched pedestrian during the walk
    do_reset();
    for (int k = 1; k < 40; k++) begin
      step();
      if (k == 7)  check("sim_walk_first", 32'(state_o), 32'd6);
      if (k == 11) check("sim_main_back", 32'(state_o), 32'd0);
      if (k == 14) check("sim_main_min", 32'(state_o), 32'd0);
      if (k == 15) check("sim_main_yel", 32'(state_o), 32'd1);
      if (k == 17) check("sim_allred", 32'(state_o), 32'd2);
      if (k == 18) check("sim_relatch_walk", 32'(state_o), 32'd6);
      vehicle_detected = (k == 1);
      ped_detected = (k == 1) || (k == 8);
    end

    // Vehicle held: side green maxes out, main then holds its minimum
    do_reset();
    vehicle_detected = 1'b1;
    wait_state(3'd3, "held_reach_side");
    cnt = 1;
    while (state_o == 3'd3 && cnt < 20) begin
      step();
      if (state_o == 3'd3) cnt++;
    end
    check("held_side_len", 32'(cnt), 32'd8);
    check("held_then_yel", 32'(state_o), 32'd4);
    wait_state(3'd0, "held_reach_main");
    cnt = 1;
    while (state_o == 3'd0 && cnt < 20) begin
      step();
      if (state_o == 3'd0) cnt++;
    end
    check("held_main_len", 32'(cnt), 32'd4);

    // Tick gating mid side green, then asynchronous reset
    do_reset();
    vehicle_detected = 1'b1;
    wait_state(3'd3, "gate_reach_side");
    step();
    tick = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("gate_frozen", 32'({state_o, side_light}), 32'({3'd3, 3'b001}));
    end
    tick = 1'b1;
    step();
    vehicle_detected = 1'b0;
    #2 reset = 1'b1;
    #1 check("async_reset", 32'({state_o, main_light, side_light, walk, ped_ack}),
             32'({3'd0, 3'b001, 3'b100, 2'b00}));
    step();
    reset = 1'b0;
    saw_side = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (state_o == 3'd3) saw_side = 1'b1;
    end
    check("no_side_after_reset", 32'(saw_side), 32'd0);

    // Randomized traffic with irregular ticks and occasional resets
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) vehicle_detected = ~vehicle_detected;
      ped_detected = ($urandom_range(0, 24) == 0);
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
